// File: rtl/bus_serial_target.sv
// bus_serial_target: target end of the serial command bus.
// Deserializes one MSB-first address/data frame, framed by a single-cycle
// start strobe on the first bit, and hands the word to local logic through
// a single-entry valid/ready holding register. Malformed frames raise a
// one-cycle frame_err pulse. A completed frame that finds the holding
// register still full is dropped, and this raises a one-cycle overrun pulse.
module bus_serial_target #(
  parameter int WIDTH = 8,
  parameter int CMD_W = 2,
  parameter logic [CMD_W-1:0] CMD_IDLE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CMD_W-1:0] cmd,
  input  logic             addr,
  input  logic             data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [CMD_W-1:0] rx_cmd,
  output logic [WIDTH-1:0] rx_addr,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  // The bit counter holds the index of the next bit still to be sampled.
  // It must be able to hold WIDTH-2 at most.
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state, state_next;
  logic [WIDTH-1:0] sa, sa_next;
  logic [WIDTH-1:0] sd, sd_next;
  logic [CMD_W-1:0] lc, lc_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             err_next;
  logic             complete;
  logic             load;

  // The shift registers with the current serial bit appended. On the last
  // bit of a frame, these are the complete words.
  logic [WIDTH-1:0] sa_shift;
  logic [WIDTH-1:0] sd_shift;
  assign sa_shift = {sa[WIDTH-2:0], addr};
  assign sd_shift = {sd[WIDTH-2:0], data};

  // Frame sequencing: start a frame, shift in its bits, detect protocol errors.
  always_comb begin
    state_next = state;
    sa_next    = sa;
    sd_next    = sd;
    lc_next    = lc;
    cnt_next   = cnt;
    err_next   = 1'b0;
    complete   = 1'b0;
    if (start) begin
      // A strobe seen mid-frame throws away the partial frame. The cycle
      // then counts as the first bit of a fresh frame.
      if (state == ST_SHIFT) begin
        err_next = 1'b1;
      end
      if (cmd != CMD_IDLE) begin
        sa_next    = sa_shift;
        sd_next    = sd_shift;
        lc_next    = cmd;
        cnt_next   = CNT_INIT;
        state_next = ST_SHIFT;
      end else begin
        err_next   = 1'b1;
        state_next = ST_IDLE;
      end
    end else if (state == ST_SHIFT) begin
      if (cmd != lc) begin
        // The command must stay the same for the whole frame.
        err_next   = 1'b1;
        state_next = ST_IDLE;
      end else begin
        sa_next  = sa_shift;
        sd_next  = sd_shift;
        cnt_next = cnt - CNT_ONE;
        if (cnt == '0) begin
          complete   = 1'b1;
          state_next = ST_IDLE;
        end
      end
    end
  end

  // The holding register can take a new word if it is empty now, or if it
  // is being emptied in this same cycle.
  assign load = complete && (!rx_valid || rx_ready);

  // Frame state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      sa    <= '0;
      sd    <= '0;
      lc    <= CMD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      sa    <= sa_next;
      sd    <= sd_next;
      lc    <= lc_next;
      cnt   <= cnt_next;
    end
  end

  // Holding register and registered status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid  <= 1'b0;
      rx_cmd    <= CMD_IDLE;
      rx_addr   <= '0;
      rx_data   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= err_next;
      overrun   <= complete && !load;
      if (load) begin
        rx_valid <= 1'b1;
        rx_cmd   <= lc;
        rx_addr  <= sa_shift;
        rx_data  <= sd_shift;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_bus_serial_target.sv
// Self-checking bench for bus_serial_target.
// It runs three kinds of test in turn: a vector table of single and
// back-to-back frames, hand-written corner-case sequences, and randomized
// frame traffic checked against a frame-level model of the holding register.
module tb_bus_serial_target;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] cmd;
  logic       addr;
  logic       data;
  logic       rx_valid;
  logic       rx_ready;
  logic [1:0] rx_cmd;
  logic [7:0] rx_addr;
  logic [7:0] rx_data;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  bus_serial_target #(.WIDTH(W), .CMD_W(2), .CMD_IDLE(2'd0)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .addr(addr), .data(data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_cmd(rx_cmd),
    .rx_addr(rx_addr), .rx_data(rx_data), .busy(busy),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] addr;
    logic [7:0] data;
    logic [1:0] exp_cmd;
    logic [7:0] exp_addr;
    logic [7:0] exp_data;
  } vec_t;

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] addr;
    logic [7:0] data;
    int         gap;
  } frame_t;

  vec_t   vecs[5];
  frame_t frames[$];

  // Frame-level model of the single-entry holding register.
  logic       mv;
  logic [1:0] mc;
  logic [7:0] ma;
  logic [7:0] md;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 1'b0;
    cmd   = 2'd0;
    addr  = 1'b0;
    data  = 1'b0;
  endtask

  task automatic drive_bit(input logic [1:0] c, input logic [7:0] a, input logic [7:0] d, input int b);
    start = (b == W - 1);
    cmd   = c;
    addr  = a[b];
    data  = d[b];
  endtask

  // Drives a whole frame. pre_valid and pre_busy are sampled one edge
  // before the last bit is taken.
  task automatic send_frame(input logic [1:0] c, input logic [7:0] a, input logic [7:0] d,
                            output logic pre_valid, output logic pre_busy);
    pre_valid = 1'b0;
    pre_busy  = 1'b0;
    for (int b = W - 1; b >= 0; b--) begin
      if (b == 0) begin
        pre_valid = rx_valid;
        pre_busy  = busy;
      end
      drive_bit(c, a, d, b);
      tick();
    end
    idle_in();
  endtask

  task automatic check_word(input string tag, input logic [1:0] c, input logic [7:0] a, input logic [7:0] d);
    check({tag, "_valid"}, rx_valid, 1'b1);
    check({tag, "_cmd"},   rx_cmd,   c);
    check({tag, "_addr"},  rx_addr,  a);
    check({tag, "_data"},  rx_data,  d);
  endtask

  // One cycle of randomized traffic. The model applies the delivery rule:
  // a completed frame is kept if the holding register is empty or is being
  // read in the same cycle; otherwise the frame is dropped as an overrun.
  task automatic rand_step(input logic in_frame, input logic [1:0] c, input logic [7:0] a,
                           input logic [7:0] d, input int b);
    logic rdy;
    logic comp;
    logic exp_ov;
    logic exp_busy;
    rdy = 1'($urandom_range(0, 1));
    rx_ready = rdy;
    if (in_frame) drive_bit(c, a, d, b);
    else idle_in();
    comp   = in_frame && (b == 0);
    exp_ov = 1'b0;
    if (comp) begin
      if (!mv || rdy) begin
        mv = 1'b1; mc = c; ma = a; md = d;
      end else begin
        exp_ov = 1'b1;
      end
    end else if (mv && rdy) begin
      mv = 1'b0;
    end
    exp_busy = in_frame && (b != 0);
    tick();
    check("rnd_valid", rx_valid, mv);
    check("rnd_overrun", overrun, exp_ov);
    check("rnd_frame_err", frame_err, 1'b0);
    check("rnd_busy", busy, exp_busy);
    if (mv) begin
      check("rnd_cmd", rx_cmd, mc);
      check("rnd_addr", rx_addr, ma);
      check("rnd_data", rx_data, md);
    end
  endtask

  initial begin
    logic pv, pb;

    vecs[0] = '{2'd2, 8'hA5, 8'h3C, 2'd2, 8'hA5, 8'h3C};
    vecs[1] = '{2'd1, 8'h01, 8'hFF, 2'd1, 8'h01, 8'hFF};
    vecs[2] = '{2'd2, 8'h80, 8'h00, 2'd2, 8'h80, 8'h00};
    vecs[3] = '{2'd3, 8'h5A, 8'hC3, 2'd3, 8'h5A, 8'hC3};
    vecs[4] = '{2'd1, 8'h00, 8'h01, 2'd1, 8'h00, 8'h01};

    // Reset state
    rst = 1'b1;
    rx_ready = 1'b0;
    idle_in();
    tick();
    tick();
    check("rst_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_cmd", rx_cmd, 2'd0);
    check("rst_addr", rx_addr, 8'h00);
    check("rst_data", rx_data, 8'h00);
    rst = 1'b0;
    tick();

    // Table: back-to-back frames with the consumer always ready
    rx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].cmd, vecs[i].addr, vecs[i].data, pv, pb);
      $display("vector %0d cmd=%0d addr=%02h data=%02h -> rx_cmd=%0d rx_addr=%02h rx_data=%02h",
               i, vecs[i].cmd, vecs[i].addr, vecs[i].data, rx_cmd, rx_addr, rx_data);
      check("tbl_pre_valid", pv, 1'b0);
      check("tbl_pre_busy", pb, 1'b1);
      check_word("tbl", vecs[i].exp_cmd, vecs[i].exp_addr, vecs[i].exp_data);
      check("tbl_busy", busy, 1'b0);
      check("tbl_frame_err", frame_err, 1'b0);
      check("tbl_overrun", overrun, 1'b0);
    end
    tick();
    check("tbl_hs_clear", rx_valid, 1'b0);

    // Overrun: consumer stalled across two frames
    rx_ready = 1'b0;
    send_frame(2'd2, 8'h11, 8'h22, pv, pb);
    $display("overrun seq: first frame done, valid=%0b", rx_valid);
    check_word("ovr_first", 2'd2, 8'h11, 8'h22);
    check("ovr_first_overrun", overrun, 1'b0);
    send_frame(2'd1, 8'h33, 8'h44, pv, pb);
    $display("overrun seq: second frame done, overrun=%0b", overrun);
    check("ovr_pulse", overrun, 1'b1);
    check_word("ovr_kept", 2'd2, 8'h11, 8'h22);
    tick();
    check("ovr_pulse_end", overrun, 1'b0);
    check("ovr_still_valid", rx_valid, 1'b1);
    rx_ready = 1'b1;
    tick();
    check("ovr_delivered_one", rx_valid, 1'b0);
    tick();
    check("ovr_no_second", rx_valid, 1'b0);

    // Completion in the same cycle as a handshake: no bubble, no overrun
    rx_ready = 1'b0;
    send_frame(2'd2, 8'h55, 8'h66, pv, pb);
    check_word("sim_first", 2'd2, 8'h55, 8'h66);
    for (int b = W - 1; b >= 1; b--) begin
      drive_bit(2'd1, 8'h77, 8'h88, b);
      tick();
    end
    rx_ready = 1'b1;
    drive_bit(2'd1, 8'h77, 8'h88, 0);
    tick();
    idle_in();
    $display("simultaneous seq: valid=%0b addr=%02h overrun=%0b", rx_valid, rx_addr, overrun);
    check_word("sim_new", 2'd1, 8'h77, 8'h88);
    check("sim_overrun", overrun, 1'b0);
    tick();
    check("sim_clear", rx_valid, 1'b0);

    // A second start strobe arrives where bit 4 of the first frame belongs
    for (int b = W - 1; b >= 5; b--) begin
      drive_bit(2'd2, 8'hF0, 8'h0F, b);
      tick();
    end
    check("rs_no_err_yet", frame_err, 1'b0);
    drive_bit(2'd1, 8'h6D, 8'hB2, W - 1);
    tick();
    check("rs_err", frame_err, 1'b1);
    check("rs_busy", busy, 1'b1);
    for (int b = W - 2; b >= 0; b--) begin
      drive_bit(2'd1, 8'h6D, 8'hB2, b);
      tick();
      if (b == W - 2) check("rs_err_end", frame_err, 1'b0);
    end
    idle_in();
    $display("restart seq: valid=%0b addr=%02h data=%02h", rx_valid, rx_addr, rx_data);
    check_word("rs_word", 2'd1, 8'h6D, 8'hB2);
    tick();

    // The command changes where bit 2 belongs
    for (int b = W - 1; b >= 3; b--) begin
      drive_bit(2'd2, 8'hC9, 8'h9C, b);
      tick();
    end
    drive_bit(2'd1, 8'hC9, 8'h9C, 2);
    tick();
    $display("cmd change seq: frame_err=%0b busy=%0b", frame_err, busy);
    check("cc_err", frame_err, 1'b1);
    check("cc_idle", busy, 1'b0);
    idle_in();
    for (int k = 0; k < 4; k++) tick();
    check("cc_err_end", frame_err, 1'b0);
    check("cc_nothing", rx_valid, 1'b0);

    // A start strobe with the idle command
    start = 1'b1;
    cmd = 2'd0;
    tick();
    idle_in();
    $display("idle-cmd start: frame_err=%0b busy=%0b", frame_err, busy);
    check("ic_err", frame_err, 1'b1);
    check("ic_busy", busy, 1'b0);
    tick();
    check("ic_err_end", frame_err, 1'b0);
    for (int k = 0; k < W + 1; k++) tick();
    check("ic_nothing", rx_valid, 1'b0);

    // Reset where bit 5 belongs, with a word already held
    rx_ready = 1'b0;
    send_frame(2'd2, 8'h99, 8'h42, pv, pb);
    check("rm_held", rx_valid, 1'b1);
    for (int b = W - 1; b >= 6; b--) begin
      drive_bit(2'd1, 8'h12, 8'h34, b);
      tick();
    end
    drive_bit(2'd1, 8'h12, 8'h34, 5);
    rst = 1'b1;
    #1;
    check("rm_valid", rx_valid, 1'b0);
    check("rm_busy", busy, 1'b0);
    check("rm_cmd", rx_cmd, 2'd0);
    check("rm_addr", rx_addr, 8'h00);
    check("rm_data", rx_data, 8'h00);
    check("rm_err", frame_err, 1'b0);
    check("rm_ovr", overrun, 1'b0);
    idle_in();
    #1;
    rst = 1'b0;
    tick();
    check("rm_after_busy", busy, 1'b0);
    check("rm_after_valid", rx_valid, 1'b0);
    rx_ready = 1'b1;
    send_frame(2'd1, 8'h12, 8'h34, pv, pb);
    $display("post-reset frame: valid=%0b addr=%02h data=%02h", rx_valid, rx_addr, rx_data);
    check_word("rm_next", 2'd1, 8'h12, 8'h34);
    tick();

    // Randomized traffic against the frame-level model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mv = 1'b0; mc = 2'd0; ma = 8'h00; md = 8'h00;
    for (int i = 0; i < 30; i++) begin
      frame_t f;
      f.cmd  = 2'($urandom_range(1, 3));
      f.addr = 8'($urandom);
      f.data = 8'($urandom);
      f.gap  = $urandom_range(0, 3);
      frames.push_back(f);
    end
    while (frames.size() > 0) begin
      frame_t f;
      f = frames.pop_front();
      for (int g = 0; g < f.gap; g++) rand_step(1'b0, 2'd0, 8'h00, 8'h00, 0);
      for (int b = W - 1; b >= 0; b--) rand_step(1'b1, f.cmd, f.addr, f.data, b);
      $display("random frame cmd=%0d addr=%02h data=%02h gap=%0d valid=%0b",
               f.cmd, f.addr, f.data, f.gap, rx_valid);
    end
    for (int k = 0; k < 4; k++) rand_step(1'b0, 2'd0, 8'h00, 8'h00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_serial_target.md
# bus_serial_target

Synthesizable target end of the serial command bus. It deserializes one frame (command plus MSB-first address and data bit streams, framed by a single-cycle `start` strobe) from the initiator and presents the assembled word on a parallel valid/ready port to local logic. It sits on the target side of the bus interface, replacing a behavioural receive task with RTL. It also flags malformed frames and dropped (overrun) frames.

## Interface
- `WIDTH`, 8: bits per address/data field (frame length in cycles).
- `CMD_W`, 2: command field width.
- `CMD_IDLE`, 0: idle command encoding (READ=1, WRITE=2, 3 reserved).
- `clk`  in  1  sole clock; all sampling on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  frame strobe; high only in the cycle carrying bit WIDTH-1.
- `cmd`  in  CMD_W  bus command; held constant for the whole frame, `CMD_IDLE` between frames.
- `addr`  in  1  serial address bit, MSB first.
- `data`  in  1  serial data bit, MSB first.
- `rx_valid`  out  1  parallel word available.
- `rx_ready`  in  1  consumer accepts the word when `rx_valid && rx_ready`.
- `rx_cmd`  out  CMD_W  latched frame command.
- `rx_addr`  out  WIDTH  assembled address.
- `rx_data`  out  WIDTH  assembled data.
- `busy`  out  1  high while a frame is being shifted in.
- `frame_err`  out  1  one-cycle pulse on a protocol error.
- `overrun`  out  1  one-cycle pulse when a completed frame is dropped.

## Operation
- States: IDLE, SHIFT. Shift registers `sa`, `sd` (WIDTH), latched command `lc`, bit counter `cnt`.
- IDLE, `start`=1 and `cmd`≠`CMD_IDLE`:
  - Sample bit WIDTH-1 of `addr` and `data`.
  - `lc`←`cmd`, `cnt`←WIDTH-2.
  - Go to SHIFT.
- IDLE, `start`=1 and `cmd`=`CMD_IDLE`: pulse `frame_err` and stay in IDLE.
- SHIFT, each cycle:
  - Shift `addr`/`data` in at the LSB.
  - Decrement `cnt`.
  - When the bit sampled had `cnt`=0, the frame is complete; go to IDLE.
- Frame completion:
  - If the holding register is free (`rx_valid`=0), or it is being emptied this cycle (`rx_valid && rx_ready`), load `rx_cmd`/`rx_addr`/`rx_data` and set `rx_valid`.
  - Otherwise pulse `overrun`, drop the frame and keep the old word.
- `start`=1 while in SHIFT:
  - Pulse `frame_err`.
  - Discard the partial frame.
  - Treat this cycle as bit WIDTH-1 of a new frame, with the same rules as IDLE.
- `cmd`≠`lc` while in SHIFT, and `start`=0: pulse `frame_err`, abort the frame and return to IDLE.
- `rx_valid` clears on handshake unless it is reloaded in the same cycle.
- Output fields hold their value while `rx_valid`=1.
- `busy` = (state==SHIFT).

## Timing
- Reset values:
  - State IDLE.
  - `rx_valid`, `busy`, `frame_err`, `overrun` = 0.
  - `rx_cmd` = `CMD_IDLE`.
  - `rx_addr`, `rx_data` = 0.
- Reset mid-frame discards the partial frame and the held word.
- Frame with `start` sampled at edge E:
  - Bits WIDTH-1..0 are sampled at edges E..E+WIDTH-1.
  - `rx_valid` is high after edge E+WIDTH-1.
  - Latency is WIDTH cycles from `start` to valid.
- Back-to-back frames are supported: a `start` at edge E+WIDTH is accepted with no gap.
- Simultaneous completion and consumer handshake: the new word replaces the old one and `rx_valid` stays 1, so there is no bubble and no overrun.
- `frame_err` and `overrun` are registered pulses. Both are asserted after the edge where the condition is sampled, for one cycle.
- Only a reset clears them early.
- No combinational path from any input to any output.

## Test plan
- Single WRITE frame, `addr`=0xA5, `data`=0x3C, `rx_ready`=1:
  - `rx_valid` rises 8 cycles after `start`.
  - `rx_cmd`=2, `rx_addr`=0xA5, `rx_data`=0x3C.
  - Handshake clears `rx_valid` next cycle.
- Back-to-back READ 0x01/0xFF then WRITE 0x80/0x00 with `rx_ready`=1: two words delivered on consecutive frame boundaries, correct in order, no error pulses.
- `rx_ready`=0 with two frames sent:
  - First word is held.
  - `overrun` pulses once at the second completion.
  - Raising `rx_ready` delivers the first word only.
- `rx_valid`=1, and `rx_ready`=1 exactly on the next frame's completion edge: the new word is loaded, `rx_valid` stays 1, `overrun`=0.
- Protocol errors:
  - `start` reasserted at bit 4: `frame_err` pulses, and the second frame is received correctly.
  - `cmd` changed at bit 2: `frame_err` pulses and the state returns to IDLE.
  - `start` with `cmd`=IDLE: `frame_err` pulses and nothing is delivered.
- Assert `rst` at bit 5 of a frame: all outputs return to reset values immediately, and the next full frame is received correctly.
